// File: rtl/mmio_map_pkg.sv
// rtl/mmio_map_pkg.sv - register map constants and decode types for mmio_mem_subsys
// Contents: MMIO byte offsets, TX_STATUS bit indices, address region enum.
package mmio_map_pkg;

    localparam logic [4:0] OFF_TX_DATA   = 5'h00;
    localparam logic [4:0] OFF_TX_STATUS = 5'h04;
    localparam logic [4:0] OFF_TMR_COUNT = 5'h08;
    localparam logic [4:0] OFF_TMR_CMP   = 5'h0C;
    localparam logic [4:0] OFF_TMR_STAT  = 5'h10;
    localparam logic [4:0] OFF_TMR_IE    = 5'h14;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_t;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte-wide TX FIFO with registered head output
// Ports: clk, rst_n (async active-low), push/din (write side),
//        pop/dout/valid (drain side), full/empty/count (status).
// A push while full is accepted only when a pop happens in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign valid   = !empty;
    // Head comes straight from storage; the slot under rd_ptr is only written
    // when the FIFO is empty or being popped, so dout is stable otherwise.
    assign dout    = empty ? 8'h00 : mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_mem_subsys.sv
// rtl/mmio_mem_subsys.sv - M-stage memory slave: data RAM, console TX FIFO, timer
// Ports: clk, reset (async active-low), MemWriteM/ALUOutM/WriteDataM (core M stage),
//        ReadDataM (combinational read), tx_data/tx_valid/tx_ready (console drain),
//        timer_irq (only when MMIO_TIMER_IRQ_EN is defined).
// Optional feature macro: MMIO_TIMER_IRQ_EN adds the ie register at 0x14 and timer_irq.
module mmio_mem_subsys #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        timer_irq
`endif
);
    import mmio_map_pkg::*;

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_t           region;
    logic [4:0]        off;
    logic              mmio_wr;
    logic              wr_tx_data, wr_tx_status, wr_count, wr_cmp, wr_stat;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic              ovf;
    logic [31:0]       tmr_count, tmr_cmp;
    logic              match;
    logic [31:0]       status, ie_rd;

    always_comb begin
        if (ALUOutM < RAM_BYTES)                    region = REG_RAM;
        else if (ALUOutM[31:5] == MMIO_BASE[31:5])  region = REG_MMIO;
        else                                        region = REG_NONE;
    end

    // Byte-lane bits are ignored, so offsets are matched on word boundaries.
    assign off          = {ALUOutM[4:2], 2'b00};
    assign mmio_wr      = MemWriteM && (region == REG_MMIO);
    assign wr_tx_data   = mmio_wr && (off == OFF_TX_DATA);
    assign wr_tx_status = mmio_wr && (off == OFF_TX_STATUS);
    assign wr_count     = mmio_wr && (off == OFF_TMR_COUNT);
    assign wr_cmp       = mmio_wr && (off == OFF_TMR_CMP);
    assign wr_stat      = mmio_wr && (off == OFF_TMR_STAT);

    assign ram_idx = ALUOutM[RAM_AW+1:2];

    always_ff @(posedge clk) begin
        if (MemWriteM && (region == REG_RAM)) ram[ram_idx] <= WriteDataM;
    end

    assign fifo_pop = tx_valid && tx_ready;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wr_tx_data),
        .din   (WriteDataM[7:0]),
        .pop   (fifo_pop),
        .dout  (tx_data),
        .valid (tx_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf       <= 1'b0;
            tmr_count <= 32'h0;
            tmr_cmp   <= 32'hFFFFFFFF;
            match     <= 1'b0;
        end else begin
            // A push into a full FIFO is only lost when nothing drains that cycle.
            if (wr_tx_data && fifo_full && !fifo_pop)      ovf <= 1'b1;
            else if (wr_tx_status && WriteDataM[ST_OVF])   ovf <= 1'b0;

            tmr_count <= wr_count ? WriteDataM : tmr_count + 32'd1;
            if (wr_cmp) tmr_cmp <= WriteDataM;

            // Compare hit wins over a same-cycle clear so no match is ever lost.
            if (tmr_count == tmr_cmp)          match <= 1'b1;
            else if (wr_stat && WriteDataM[0]) match <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic ie;
    logic wr_ie;

    assign wr_ie = mmio_wr && (off == OFF_TMR_IE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     ie <= 1'b0;
        else if (wr_ie) ie <= WriteDataM[0];
    end

    assign timer_irq = match & ie;
    assign ie_rd     = {31'b0, ie};
`else
    assign ie_rd     = 32'b0;
`endif

    always_comb begin
        status           = 32'b0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf;
        status[15:8]     = 8'(fifo_count);
    end

    always_comb begin
        ReadDataM = 32'b0;
        case (region)
            REG_RAM:  ReadDataM = ram[ram_idx];
            REG_MMIO: begin
                case (off)
                    OFF_TX_STATUS: ReadDataM = status;
                    OFF_TMR_COUNT: ReadDataM = tmr_count;
                    OFF_TMR_CMP:   ReadDataM = tmr_cmp;
                    OFF_TMR_STAT:  ReadDataM = {31'b0, match};
                    OFF_TMR_IE:    ReadDataM = ie_rd;
                    default:       ReadDataM = 32'b0;
                endcase
            end
            default:  ReadDataM = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_mmio_mem_subsys.sv
// tb/tb_mmio_mem_subsys.sv - self-checking bench for mmio_mem_subsys
module tb_mmio_mem_subsys;

    localparam logic [31:0] BASE = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef MMIO_TIMER_IRQ_EN
    logic        timer_irq;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    mmio_mem_subsys dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
`ifdef MMIO_TIMER_IRQ_EN
        ,
        .timer_irq  (timer_irq)
`endif
    );

    // Reference model: RAM as sparse word map, FIFO as a byte queue, timer as plain integers.
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic        m_ovf, m_match, m_ie;
    logic [31:0] m_cnt, m_cmp;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'h1000) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd1: return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == 0, m_q.size() == 8};
            3'd2: return m_cnt;
            3'd3: return m_cmp;
            3'd4: return {31'h0, m_match};
`ifdef MMIO_TIMER_IRQ_EN
            3'd5: return {31'h0, m_ie};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_ovf = 0; m_match = 0; m_ie = 0;
        m_cnt = 32'h0; m_cmp = 32'hFFFFFFFF;
    endtask

    task automatic m_tick();
        logic pop, mw, hit;
        logic [2:0] w;
        pop = (m_q.size() != 0) && tx_ready;
        mw  = MemWriteM && (ALUOutM[31:5] == BASE[31:5]);
        w   = ALUOutM[4:2];
        hit = (m_cnt == m_cmp);
        if (pop) void'(m_q.pop_front());
        if (mw && w == 3'd0) begin
            if (m_q.size() < 8) m_q.push_back(WriteDataM[7:0]);
            else m_ovf = 1;
        end
        if (mw && w == 3'd1 && WriteDataM[2]) m_ovf = 0;
        m_cnt = (mw && w == 3'd2) ? WriteDataM : m_cnt + 32'd1;
        if (mw && w == 3'd3) m_cmp = WriteDataM;
        if (hit) m_match = 1;
        else if (mw && w == 3'd4 && WriteDataM[0]) m_match = 0;
`ifdef MMIO_TIMER_IRQ_EN
        if (mw && w == 3'd5) m_ie = WriteDataM[0];
`endif
        if (MemWriteM && ALUOutM < 32'h1000) m_ram[int'(ALUOutM >> 2)] = WriteDataM;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        m_tick();
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWriteM = we; ALUOutM = a; WriteDataM = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        clk_cycle();
        drive(1'b0, a, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, a, 32'h0);
        #1;
        chk(name, ReadDataM, exp);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        chk_en;
    } vec_t;

    vec_t vt[$];

    task automatic add(input string n, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e, input logic c);
        vt.push_back('{n, we, a, d, e, c});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, exp8;
        logic        we;
        int          op;

        reset = 1'b0; tx_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        rd_chk("rst_count", BASE + 32'h8, 0);

        add("st_reset",   0, BASE + 32'h4,  0, 32'h2,        1);
        add("cmp_reset",  0, BASE + 32'hC,  0, 32'hFFFFFFFF, 1);
        add("stat_reset", 0, BASE + 32'h10, 0, 32'h0,        1);
        add("txd_read0",  0, BASE,          0, 32'h0,        1);
        add("wr_0",       1, 32'h0,  32'h0BADF00D, 0, 0);
        add("wr_beef",    1, 32'h10, 32'hDEADBEEF, 0, 0);
        add("rd_10",      0, 32'h10,   0, 32'hDEADBEEF, 1);
        add("rd_13",      0, 32'h13,   0, 32'hDEADBEEF, 1);
        add("rd_2000",    0, 32'h2000, 0, 32'h0,        1);
        add("wr_1000",    1, 32'h1000, 32'h55, 0, 0);
        add("rd_1000",    0, 32'h1000, 0, 32'h0,        1);
        add("rd_0",       0, 32'h0,    0, 32'h0BADF00D, 1);
        add("rd_outwin",  0, 32'hFFFF0020, 0, 32'h0,    1);
        add("off_18",     0, BASE + 32'h18, 0, 32'h0,   1);
        add("off_1c",     0, BASE + 32'h1C, 0, 32'h0,   1);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].wd);
            #1;
            if (vt[i].chk_en) chk(vt[i].name, ReadDataM, vt[i].exp);
            clk_cycle();
        end
        drive(1'b0, 32'h0, 32'h0);

        // Fill to full, then overflow, then clear overflow.
        for (int i = 1; i <= 9; i++) begin
            wr(BASE, i);
            if (i == 8) rd_chk("fill_full", BASE + 32'h4, 32'h0801);
        end
        rd_chk("fill_ovf", BASE + 32'h4, 32'h0805);
        wr(BASE + 32'h4, 32'h4);
        rd_chk("ovf_clr", BASE + 32'h4, 32'h0801);

        // Back-to-back drain.
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", tx_valid, 1);
            chk("drain_data", tx_data, i);
            clk_cycle();
        end
        tx_ready = 1'b0;
        chk("drain_done_valid", tx_valid, 0);
        chk("drain_done_data", tx_data, 0);
        rd_chk("drain_status", BASE + 32'h4, 32'h2);

        // Push while full with a simultaneous pop.
        for (int i = 0; i < 8; i++) wr(BASE, 32'h11 + i);
        tx_ready = 1'b1;
        wr(BASE, 32'hAA);
        rd_chk("pp_status", BASE + 32'h4, 32'h0801);
        for (int i = 0; i < 8; i++) begin
            exp8 = (i < 7) ? 32'h12 + i : 32'hAA;
            chk("pp_data", tx_data, exp8);
            clk_cycle();
        end
        tx_ready = 1'b0;
        chk("pp_empty", tx_valid, 0);

        // Timer compare, sticky match, set-over-clear.
        wr(BASE + 32'hC, 32'd20);
        wr(BASE + 32'h8, 32'd10);
        rd_chk("tmr_load", BASE + 32'h8, 32'd10);
        repeat (10) clk_cycle();
        rd_chk("tmr_at20", BASE + 32'h8, 32'd20);
        rd_chk("tmr_nomatch", BASE + 32'h10, 0);
        clk_cycle();
        rd_chk("tmr_match", BASE + 32'h10, 1);
        rd_chk("tmr_after", BASE + 32'h8, 32'd21);
        wr(BASE + 32'h10, 32'h1);
        rd_chk("tmr_w1c", BASE + 32'h10, 0);
        wr(BASE + 32'h8, 32'd17);
        repeat (3) clk_cycle();
        rd_chk("tmr_eq_cmp", BASE + 32'h8, 32'd20);
        wr(BASE + 32'h10, 32'h1);
        rd_chk("tmr_set_wins", BASE + 32'h10, 1);
`ifdef MMIO_TIMER_IRQ_EN
        chk("irq_off", timer_irq, 0);
        wr(BASE + 32'h14, 32'h1);
        rd_chk("ie_rd", BASE + 32'h14, 1);
        chk("irq_on", timer_irq, 1);
`else
        wr(BASE + 32'h14, 32'h1);
        rd_chk("ie_absent", BASE + 32'h14, 0);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 9);
            we = 1'b0; d = $urandom; a = BASE + 32'h4;
            case (op)
                0, 1: begin we = 1'b1; a = 32'h80 + 4 * $urandom_range(0, 15); end
                2:    a = 32'h80 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                3, 4: begin we = 1'b1; a = BASE + $urandom_range(0, 3); end
                5:    begin we = 1'($urandom_range(0, 1)); a = BASE + 32'h4; end
                6:    begin
                          we = 1'b1; a = BASE + 32'h8;
                          if ($urandom_range(0, 3) == 0) d = 32'hFFFFFFFE;
                      end
                7:    begin we = 1'b1; a = BASE + 32'hC; d = m_cnt + $urandom_range(0, 6); end
                8:    begin we = 1'($urandom_range(0, 1)); a = BASE + 32'h10; end
                default: a = BASE + $urandom_range(0, 31);
            endcase
            tx_ready = 1'($urandom_range(0, 1));
            drive(we, a, d);
            #1;
            if (a >= 32'h1000 || m_ram.exists(int'(a >> 2))) chk("rnd_rd", ReadDataM, m_read(a));
            chk("rnd_valid", tx_valid, m_q.size() != 0);
            chk("rnd_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
            clk_cycle();
        end

        drive(1'b0, BASE + 32'h4, 32'h0);
        tx_ready = 1'b1;
        repeat (10) clk_cycle();
        chk("flush_valid", tx_valid, 0);

        // Asynchronous reset in the middle of a drain.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(BASE, 32'h30 + i);
        tx_ready = 1'b1;
        clk_cycle();
        chk("pre_rst_valid", tx_valid, 1);
        chk("pre_rst_data", tx_data, 32'h31);
        drive(1'b0, BASE + 32'h4, 32'h0);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", tx_valid, 0);
        chk("arst_status", ReadDataM, 32'h2);
        rd_chk("arst_count", BASE + 32'h8, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        m_reset();
        rd_chk("ram_kept", 32'h10, 32'hDEADBEEF);
        rd_chk("post_rst_status", BASE + 32'h4, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
